// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin values, one-hot coin encodings, credit limit and
// the payout state enum.
package vm_pkg;

  localparam int unsigned CoinVal3 = 20;
  localparam int unsigned CoinVal2 = 10;
  localparam int unsigned CoinVal1 = 5;
  localparam int unsigned CoinVal0 = 1;

  // Same bit order as the insertion switches
  localparam logic [3:0] CoinSel3 = 4'b1000;
  localparam logic [3:0] CoinSel2 = 4'b0100;
  localparam logic [3:0] CoinSel1 = 4'b0010;
  localparam logic [3:0] CoinSel0 = 4'b0001;

  localparam int unsigned MaxCredit = 99;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StOffer,
    StGap,
    StDone,
    StFault
  } disp_state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Return-request, coin-hopper handshake and status signals of the change dispenser.
interface change_dispenser_if;
  logic       return_req;
  logic [7:0] credit;
  logic       coin_ack;
  logic       coin_valid;
  logic [3:0] coin_sel;
  logic       busy;
  logic       credit_clr;
  logic       done;
  logic       fault;
  logic [7:0] remaining;

  modport master (
    input  return_req, credit, coin_ack,
    output coin_valid, coin_sel, busy, credit_clr, done, fault, remaining
  );

  modport slave (
    output return_req, credit, coin_ack,
    input  coin_valid, coin_sel, busy, credit_clr, done, fault, remaining
  );
endinterface

// File: rtl/coin_pick.sv
// Greedy coin chooser: largest coin not exceeding the remaining credit, as one-hot and value.
module coin_pick import vm_pkg::*; #(
  parameter int unsigned COIN3 = CoinVal3,
  parameter int unsigned COIN2 = CoinVal2,
  parameter int unsigned COIN1 = CoinVal1,
  parameter int unsigned COIN0 = CoinVal0
) (
  input  logic [7:0] remaining_i,
  output logic [3:0] sel_o,
  output logic [7:0] value_o
);

  logic [31:0] rem_w;
  assign rem_w = 32'(remaining_i);

  always_comb begin
    sel_o   = '0;
    value_o = '0;
    if (rem_w >= COIN3) begin
      sel_o   = CoinSel3;
      value_o = 8'(COIN3);
    end else if (rem_w >= COIN2) begin
      sel_o   = CoinSel2;
      value_o = 8'(COIN2);
    end else if (rem_w >= COIN1) begin
      sel_o   = CoinSel1;
      value_o = 8'(COIN1);
    end else if (rem_w != 0 && rem_w >= COIN0) begin
      sel_o   = CoinSel0;
      value_o = 8'(COIN0);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Coin-return engine: snapshots credit on request and pays it out greedily, one hopper
// handshake per coin, then pulses credit_clr/done. Illegal credit or hopper timeout is sticky.
module change_dispenser import vm_pkg::*; #(
  parameter int unsigned COIN3       = CoinVal3,
  parameter int unsigned COIN2       = CoinVal2,
  parameter int unsigned COIN1       = CoinVal1,
  parameter int unsigned COIN0       = CoinVal0,
  parameter int unsigned MAX_CREDIT  = MaxCredit,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  change_dispenser_if.master  disp_io
);

  disp_state_e state_q;
  logic [7:0]  remaining_q;
  logic [3:0]  sel_q;
  logic [7:0]  value_q;
  logic [15:0] cnt_q;

  logic [3:0]  pick_sel;
  logic [7:0]  pick_val;

  coin_pick #(
    .COIN3 (COIN3),
    .COIN2 (COIN2),
    .COIN1 (COIN1),
    .COIN0 (COIN0)
  ) u_coin_pick (
    .remaining_i (remaining_q),
    .sel_o       (pick_sel),
    .value_o     (pick_val)
  );

  // cnt_q is the GAP settle counter in StGap and the ack-wait counter in StOffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      sel_q       <= '0;
      value_q     <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (disp_io.return_req) begin
            if (32'(disp_io.credit) <= MAX_CREDIT) begin
              remaining_q <= disp_io.credit;
              state_q     <= StSelect;
            end else begin
              state_q <= StFault;
            end
          end
        end
        StSelect: begin
          if (remaining_q == '0) begin
            state_q <= StDone;
          end else if (pick_sel == '0) begin
            // Only reachable with a smallest coin larger than 1: amount cannot be paid
            state_q <= StFault;
          end else begin
            sel_q   <= pick_sel;
            value_q <= pick_val;
            cnt_q   <= 16'(ACK_TIMEOUT);
            state_q <= StOffer;
          end
        end
        StOffer: begin
          if (disp_io.coin_ack) begin
            remaining_q <= remaining_q - value_q;
            cnt_q       <= 16'(GAP_CYCLES - 1);
            state_q     <= StGap;
          end else if (cnt_q == '0) begin
            state_q <= StFault;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            state_q <= StSelect;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        StDone:  state_q <= StIdle;
        StFault: state_q <= StFault;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign disp_io.coin_valid = (state_q == StOffer);
  assign disp_io.coin_sel   = (state_q == StOffer) ? sel_q : 4'b0000;
  assign disp_io.busy       = (state_q == StSelect) || (state_q == StOffer) ||
                              (state_q == StGap)    || (state_q == StDone);
  assign disp_io.credit_clr = (state_q == StDone);
  assign disp_io.done       = (state_q == StDone);
  assign disp_io.fault      = (state_q == StFault);
  assign disp_io.remaining  = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table of payout scenarios plus a mid-payout reset
// sequence; a hopper process acks coins and scores them against an expected-coin queue.
module tb_change_dispenser;

  localparam int unsigned AckTimeout = 8;

  logic clk;
  logic rst_n;

  change_dispenser_if dif();

  change_dispenser #(
    .GAP_CYCLES  (4),
    .ACK_TIMEOUT (AckTimeout)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .disp_io (dif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;
  int ack_delay = 0;
  bit ack_stuck = 1'b0;
  int exp_q[$];

  typedef struct packed {
    logic [7:0]      credit;
    logic [7:0]      ack_delay;
    logic            stuck;
    logic [3:0]      ncoins;
    logic [9:0][7:0] coins;     // coins[0] is paid first
    logic            exp_fault;
    logic [7:0]      exp_rem;
    logic [7:0]      exp_end;   // cycle of done (or first fault) after the request edge
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sel_value(input logic [3:0] sel);
    case (sel)
      4'b1000: return 32'd20;
      4'b0100: return 32'd10;
      4'b0010: return 32'd5;
      4'b0001: return 32'd1;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_coin_valid"}, dif.coin_valid, 0);
    chk({tag, "_coin_sel"},   dif.coin_sel,   0);
    chk({tag, "_busy"},       dif.busy,       0);
    chk({tag, "_credit_clr"}, dif.credit_clr, 0);
    chk({tag, "_done"},       dif.done,       0);
    chk({tag, "_fault"},      dif.fault,      0);
    chk({tag, "_remaining"},  dif.remaining,  0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Hopper model: drives coin_ack, checks sel stability and scores accepted coins.
  initial begin
    logic [3:0] held_sel;
    bit in_offer;
    int wait_cnt;
    logic [31:0] val;
    dif.coin_ack = 1'b0;
    in_offer = 1'b0;
    wait_cnt = 0;
    held_sel = '0;
    forever begin
      @(negedge clk);
      if (dif.coin_valid) begin
        if (in_offer) chk("coin_sel_stable", dif.coin_sel, held_sel);
        else begin
          held_sel = dif.coin_sel;
          in_offer = 1'b1;
        end
        if (!ack_stuck && wait_cnt >= ack_delay) begin
          dif.coin_ack = 1'b1;
          val = sel_value(dif.coin_sel);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_coin: got value %0d, expected no coin", val);
          end else begin
            n_checks--;
            chk("coin_value", val, exp_q.pop_front());
          end
          in_offer = 1'b0;
          wait_cnt = 0;
        end else begin
          dif.coin_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        dif.coin_ack = 1'b0;
        in_offer = 1'b0;
        wait_cnt = 0;
        chk("coin_sel_idle", dif.coin_sel, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int cyc, end_cyc, ndone, nclr, nvalid, nbusy;

    rst_n = 1'b0;
    dif.return_req = 1'b0;
    dif.credit = '0;

    vecs[0] = '{credit: 8'd38, ack_delay: 8'd0, stuck: 1'b0, ncoins: 4'd6,
                coins: {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd5, 8'd10, 8'd20},
                exp_fault: 1'b0, exp_rem: 8'd0, exp_end: 8'd38};
    vecs[1] = '{credit: 8'd0, ack_delay: 8'd0, stuck: 1'b0, ncoins: 4'd0, coins: '0,
                exp_fault: 1'b0, exp_rem: 8'd0, exp_end: 8'd2};
    vecs[2] = '{credit: 8'd99, ack_delay: 8'd3, stuck: 1'b0, ncoins: 4'd10,
                coins: {8'd1, 8'd1, 8'd1, 8'd1, 8'd5, 8'd10, 8'd20, 8'd20, 8'd20, 8'd20},
                exp_fault: 1'b0, exp_rem: 8'd0, exp_end: 8'd92};
    vecs[3] = '{credit: 8'd19, ack_delay: 8'd1, stuck: 1'b0, ncoins: 4'd6,
                coins: {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd5, 8'd10},
                exp_fault: 1'b0, exp_rem: 8'd0, exp_end: 8'd44};
    vecs[4] = '{credit: 8'd100, ack_delay: 8'd0, stuck: 1'b0, ncoins: 4'd0, coins: '0,
                exp_fault: 1'b1, exp_rem: 8'd0, exp_end: 8'd1};
    vecs[5] = '{credit: 8'd120, ack_delay: 8'd0, stuck: 1'b0, ncoins: 4'd0, coins: '0,
                exp_fault: 1'b1, exp_rem: 8'd0, exp_end: 8'd1};
    vecs[6] = '{credit: 8'd7, ack_delay: 8'd0, stuck: 1'b1, ncoins: 4'd0, coins: '0,
                exp_fault: 1'b1, exp_rem: 8'd7, exp_end: 8'(AckTimeout + 3)};

    do_reset();
    @(negedge clk);
    chk_outputs_zero("reset");

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      do_reset();
      ack_delay = int'(v.ack_delay);
      ack_stuck = v.stuck;
      for (int c = 0; c < int'(v.ncoins); c++) exp_q.push_back(int'(v.coins[c]));
      @(negedge clk);
      dif.credit = v.credit;
      dif.return_req = 1'b1;
      @(negedge clk);
      dif.return_req = 1'b0;
      cyc = 1;
      end_cyc = -1;
      ndone = 0;
      nclr = 0;
      while (cyc <= 200) begin
        if (dif.done) ndone++;
        if (dif.credit_clr) nclr++;
        if (end_cyc < 0 && (v.exp_fault ? dif.fault : dif.done)) end_cyc = cyc;
        if (end_cyc >= 0 && cyc >= end_cyc + 3) break;
        @(negedge clk);
        cyc++;
      end
      $display("vector %0d: credit=%0d end_cycle=%0d", i, v.credit, end_cyc);
      chk("end_cycle", end_cyc, int'(v.exp_end));
      chk("done_pulses", ndone, v.exp_fault ? 0 : 1);
      chk("credit_clr_pulses", nclr, v.exp_fault ? 0 : 1);
      chk("fault", dif.fault, v.exp_fault);
      chk("busy_end", dif.busy, 0);
      chk("coin_valid_end", dif.coin_valid, 0);
      chk("remaining", dif.remaining, v.exp_rem);
      chk("coins_outstanding", exp_q.size(), 0);
    end

    // Request during payout is dropped; reset in GAP kills the payout without credit_clr.
    ack_stuck = 1'b0;
    ack_delay = 0;
    do_reset();
    exp_q.push_back(20);
    nclr = 0;
    @(negedge clk);
    dif.credit = 8'd38;
    dif.return_req = 1'b1;
    @(negedge clk);
    dif.return_req = 1'b0;
    cyc = 0;
    while (!dif.coin_valid && cyc < 10) begin
      if (dif.credit_clr) nclr++;
      @(negedge clk);
      cyc++;
    end
    chk("mid_offer_seen", dif.coin_valid, 1);
    @(negedge clk);
    chk("mid_gap_busy", dif.busy, 1);
    chk("mid_gap_valid", dif.coin_valid, 0);
    chk("mid_gap_remaining", dif.remaining, 18);
    dif.credit = 8'd50;
    dif.return_req = 1'b1;
    @(negedge clk);
    dif.return_req = 1'b0;
    chk("mid_req_ignored_remaining", dif.remaining, 18);
    chk("mid_req_ignored_busy", dif.busy, 1);
    if (dif.credit_clr) nclr++;
    #2 rst_n = 1'b0;
    #1;
    chk_outputs_zero("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    nbusy = 0;
    repeat (20) begin
      @(negedge clk);
      if (dif.coin_valid) nvalid++;
      if (dif.busy) nbusy++;
      if (dif.credit_clr) nclr++;
    end
    chk("post_rst_coin_valid_cycles", nvalid, 0);
    chk("post_rst_busy_cycles", nbusy, 0);
    chk("mid_seq_credit_clr_pulses", nclr, 0);
    chk("mid_seq_coins_outstanding", exp_q.size(), 0);
    chk("post_rst_remaining", dif.remaining, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
